// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module  : timer_counter
// Purpose : Counting core of the 8-bit timer. Selects a tick source, runs the
//           up/down counter between the effective limits, raises one-cycle
//           overflow/match pulses and shapes the timer output waveform.
// Rev     : 1.0 - initial release
// ============================================================================
module timer_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       count_mode,
  input  logic       clock_select,
  input  logic       edge_mode,
  input  logic [2:0] prescaler,
  input  logic       force_free,
  input  logic [7:0] count_min,
  input  logic [7:0] count_max,
  input  logic [7:0] count_init,
  input  logic       cnt_init_wr,
  input  logic [7:0] match_0_value,
  input  logic [7:0] match_1_value,
  input  logic       pwm_mode,
  input  logic       inv,
  input  logic       overflow_trg_en,
  input  logic       out_match_0_trg_en,
  input  logic       out_match_1_trg_en,
  input  logic       ext_in,
  output logic [7:0] count,
  output logic       overflow,
  output logic       match_0,
  output logic       match_1,
  output logic       timer_out
);

  // A single-flop synchroniser is not safe; depth is clamped to at least two.
  localparam int C_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int C_PSC_W  = 7;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [C_STAGES-1:0] sync_q;
  logic                edge_q;
  logic [C_PSC_W-1:0]  psc_q,      psc_d;
  logic [7:0]          count_q,    count_d;
  logic                overflow_q, overflow_d;
  logic                match_0_q,  match_0_d;
  logic                match_1_q,  match_1_d;
  logic                toggle_q,   toggle_d;
  logic                timer_out_q, timer_out_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]         max_eff_w;
  logic [7:0]         min_eff_w;
  logic [C_PSC_W-1:0] psc_mask_w;
  logic               sync_last_w;
  logic               ext_rise_w;
  logic               ext_fall_w;
  logic               ext_tick_w;
  logic               int_tick_w;
  logic               tick_w;
  logic               advance_w;
  logic               trig_w;

  assign max_eff_w = force_free ? 8'hFF : count_max;
  assign min_eff_w = force_free ? 8'h00 : count_min;

  // Terminal prescale value is 2^prescaler - 1 (all ones in the low bits).
  assign psc_mask_w = C_PSC_W'((8'd1 << prescaler) - 8'd1);
  assign int_tick_w = (psc_q == psc_mask_w);

  // The edge flop holds the previous synchronised level for edge detection.
  assign sync_last_w = sync_q[C_STAGES-1];
  assign ext_rise_w  = sync_last_w & ~edge_q;
  assign ext_fall_w  = ~sync_last_w & edge_q;
  assign ext_tick_w  = edge_mode ? ext_fall_w : ext_rise_w;

  assign tick_w    = clock_select ? ext_tick_w : int_tick_w;
  assign advance_w = start & tick_w & ~cnt_init_wr;

  // Any enabled event pulse from the previous cycle flips the toggle once.
  assign trig_w = (overflow_q & overflow_trg_en)
                | (match_0_q  & out_match_0_trg_en)
                | (match_1_q  & out_match_1_trg_en);

  // Synchroniser and edge flop run continuously, independent of start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[C_STAGES-2:0], ext_in};
      edge_q <= sync_last_w;
    end
  end

  // Prescaler next state: cleared when stopped or on a load, else wraps at mask.
  always_comb begin
    psc_d = psc_q;
    if (!start || cnt_init_wr) begin
      psc_d = '0;
    end else if (!clock_select) begin
      if (int_tick_w) begin
        psc_d = '0;
      end else begin
        psc_d = psc_q + C_PSC_W'(1);
      end
    end
  end

  // Count next state and event pulses; a load has priority and never pulses.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    match_0_d  = 1'b0;
    match_1_d  = 1'b0;
    if (cnt_init_wr) begin
      count_d = count_init;
    end else if (advance_w) begin
      if (!count_mode) begin
        if (count_q >= max_eff_w) begin
          count_d    = min_eff_w;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end else begin
        if (count_q <= min_eff_w) begin
          count_d    = max_eff_w;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      match_0_d = (count_d == match_0_value);
      match_1_d = (count_d == match_1_value);
    end
  end

  // Toggle next state: cleared by a load, held while in PWM mode.
  always_comb begin
    toggle_d = toggle_q;
    if (cnt_init_wr) begin
      toggle_d = 1'b0;
    end else if (!pwm_mode && trig_w) begin
      toggle_d = ~toggle_q;
    end
  end

  // Output waveform is derived from the current registered count/toggle.
  always_comb begin
    timer_out_d = inv ^ (pwm_mode ? (count_q < match_0_value) : toggle_q);
  end

  // Main state register for the counting core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q       <= '0;
      count_q     <= 8'h00;
      overflow_q  <= 1'b0;
      match_0_q   <= 1'b0;
      match_1_q   <= 1'b0;
      toggle_q    <= 1'b0;
      timer_out_q <= 1'b0;
    end else begin
      psc_q       <= psc_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      match_0_q   <= match_0_d;
      match_1_q   <= match_1_d;
      toggle_q    <= toggle_d;
      timer_out_q <= timer_out_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign match_0   = match_0_q;
  assign match_1   = match_1_q;
  assign timer_out = timer_out_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_counter
// Purpose : Directed self-checking bench for timer_counter.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       count_mode;
  logic       clock_select;
  logic       edge_mode;
  logic [2:0] prescaler;
  logic       force_free;
  logic [7:0] count_min;
  logic [7:0] count_max;
  logic [7:0] count_init;
  logic       cnt_init_wr;
  logic [7:0] match_0_value;
  logic [7:0] match_1_value;
  logic       pwm_mode;
  logic       inv;
  logic       overflow_trg_en;
  logic       out_match_0_trg_en;
  logic       out_match_1_trg_en;
  logic       ext_in;
  logic [7:0] count;
  logic       overflow;
  logic       match_0;
  logic       match_1;
  logic       timer_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] t1_cnt [5] = '{8'd3, 8'd4, 8'd5, 8'd2, 8'd3};
  logic       t1_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] t3_cnt [4] = '{8'h12, 8'h11, 8'h10, 8'h13};
  logic       t3_ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       t3_m1  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  timer_counter #(.SYNC_STAGES(2)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .count_mode         (count_mode),
    .clock_select       (clock_select),
    .edge_mode          (edge_mode),
    .prescaler          (prescaler),
    .force_free         (force_free),
    .count_min          (count_min),
    .count_max          (count_max),
    .count_init         (count_init),
    .cnt_init_wr        (cnt_init_wr),
    .match_0_value      (match_0_value),
    .match_1_value      (match_1_value),
    .pwm_mode           (pwm_mode),
    .inv                (inv),
    .overflow_trg_en    (overflow_trg_en),
    .out_match_0_trg_en (out_match_0_trg_en),
    .out_match_1_trg_en (out_match_1_trg_en),
    .ext_in             (ext_in),
    .count              (count),
    .overflow           (overflow),
    .match_0            (match_0),
    .match_1            (match_1),
    .timer_out          (timer_out)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; sampling and driving happen 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] v);
    count_init  = v;
    cnt_init_wr = 1'b1;
    step(1);
    cnt_init_wr = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] exp_cnt;
    logic       exp_to;
    int         ones;

    rst = 1'b1; start = 1'b0; count_mode = 1'b0; clock_select = 1'b0;
    edge_mode = 1'b0; prescaler = 3'd0; force_free = 1'b0;
    count_min = 8'd0; count_max = 8'd0; count_init = 8'd0; cnt_init_wr = 1'b0;
    match_0_value = 8'h80; match_1_value = 8'h81; pwm_mode = 1'b0; inv = 1'b0;
    overflow_trg_en = 1'b0; out_match_0_trg_en = 1'b0; out_match_1_trg_en = 1'b0;
    ext_in = 1'b0;

    // Reset state
    step(2);
    chk("rst_count", count, 8'd0);
    chk("rst_ovf", overflow, 8'd0);
    chk("rst_m0", match_0, 8'd0);
    chk("rst_m1", match_1, 8'd0);
    chk("rst_tout", timer_out, 8'd0);
    rst = 1'b0;
    step(1);

    // 1: up count between limits 2..5, tick every cycle
    count_min = 8'd2; count_max = 8'd5;
    load(8'd2);
    chk("t1_load", count, 8'd2);
    chk("t1_load_ovf", overflow, 8'd0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t1_count", count, t1_cnt[i]);
      chk("t1_ovf", overflow, 8'(t1_ovf[i]));
    end
    // Out-of-range load reloads to min on the next tick
    load(8'h20);
    chk("t1_oor_load", count, 8'h20);
    step(1);
    chk("t1_oor_count", count, 8'd2);
    chk("t1_oor_ovf", overflow, 8'd1);
    // min > max: every tick reloads and pulses overflow
    count_min = 8'd8;
    load(8'd8);
    step(1);
    chk("t1_inv_count", count, 8'd8);
    chk("t1_inv_ovf", overflow, 8'd1);
    step(1);
    chk("t1_inv_count2", count, 8'd8);
    chk("t1_inv_ovf2", overflow, 8'd1);

    // 2: prescaler=2, free-running up count
    start = 1'b0; force_free = 1'b1; prescaler = 3'd2;
    load(8'd0);
    start = 1'b1;
    step(3);
    chk("t2_hold3", count, 8'd0);
    step(1);
    chk("t2_tick4", count, 8'd1);
    load(8'hFE);
    step(3);
    chk("t2_fe_hold", count, 8'hFE);
    step(1);
    chk("t2_ff", count, 8'hFF);
    chk("t2_ff_ovf", overflow, 8'd0);
    step(4);
    chk("t2_wrap", count, 8'h00);
    chk("t2_wrap_ovf", overflow, 8'd1);
    step(1);
    chk("t2_ovf_end", overflow, 8'd0);
    step(1);
    start = 1'b0;
    step(5);
    chk("t2_stop_hold", count, 8'h00);
    chk("t2_stop_ovf", overflow, 8'd0);
    start = 1'b1;
    step(3);
    chk("t2_restart3", count, 8'h00);
    step(1);
    chk("t2_restart4", count, 8'h01);

    // 3: down mode 0x13..0x10 with match_1 at 0x11
    start = 1'b0; count_mode = 1'b1; force_free = 1'b0; prescaler = 3'd0;
    count_min = 8'h10; count_max = 8'h13; match_1_value = 8'h11;
    load(8'h13);
    chk("t3_load", count, 8'h13);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t3_count", count, t3_cnt[i]);
      chk("t3_ovf", overflow, 8'(t3_ovf[i]));
      chk("t3_m1", match_1, 8'(t3_m1[i]));
    end

    // 4: external clock, falling edges then rising edges
    start = 1'b0; count_mode = 1'b0; force_free = 1'b1; match_1_value = 8'h81;
    clock_select = 1'b1; edge_mode = 1'b1; ext_in = 1'b0;
    load(8'd0);
    start = 1'b1;
    ext_in = 1'b1; step(5);
    chk("t4_rise_ign", count, 8'd0);
    ext_in = 1'b0; step(2);
    chk("t4_fall_lat2", count, 8'd0);
    step(1);
    chk("t4_fall_lat3", count, 8'd1);
    step(2);
    ext_in = 1'b1; step(5);
    chk("t4_rise_ign2", count, 8'd1);
    ext_in = 1'b0; step(3);
    chk("t4_fall2", count, 8'd2);
    step(2);
    edge_mode = 1'b0;
    ext_in = 1'b1; step(2);
    chk("t4_rise_lat2", count, 8'd2);
    step(1);
    chk("t4_rise_lat3", count, 8'd3);
    step(2);
    ext_in = 1'b0; step(5);
    chk("t4_fall_ign", count, 8'd3);

    // 5: PWM, period 10, duty 3; then inverted
    start = 1'b0; clock_select = 1'b0; force_free = 1'b0;
    count_min = 8'd0; count_max = 8'd9; match_0_value = 8'd3; pwm_mode = 1'b1;
    load(8'd0);
    start = 1'b1;
    exp_cnt = 8'd0;
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) inv = 1'b1;
      exp_to  = (exp_cnt < 8'd3) ^ inv;
      exp_cnt = (exp_cnt == 8'd9) ? 8'd0 : exp_cnt + 8'd1;
      step(1);
      chk("t5_count", count, exp_cnt);
      chk("t5_tout", timer_out, 8'(exp_to));
      if (i < 10 && timer_out === 1'b1) ones++;
    end
    chk("t5_duty", 8'(ones), 8'd3);

    // 6: toggle on match_0, load with prescaler, async reset
    start = 1'b0; pwm_mode = 1'b0; inv = 1'b0;
    out_match_0_trg_en = 1'b1; match_0_value = 8'd4;
    load(8'd0);
    start = 1'b1;
    step(4);
    chk("t6_m0_cnt", count, 8'd4);
    chk("t6_m0", match_0, 8'd1);
    step(1);
    chk("t6_tout_lag", timer_out, 8'd0);
    step(1);
    chk("t6_tout_hi", timer_out, 8'd1);
    step(9);
    chk("t6_tout_hold", timer_out, 8'd1);
    step(1);
    chk("t6_tout_lo", timer_out, 8'd0);
    prescaler = 3'd3; match_1_value = 8'd7;
    load(8'd7);
    chk("t6_load", count, 8'd7);
    chk("t6_load_ovf", overflow, 8'd0);
    chk("t6_load_m0", match_0, 8'd0);
    chk("t6_load_m1", match_1, 8'd0);
    step(7);
    chk("t6_psc_hold", count, 8'd7);
    step(1);
    chk("t6_psc_tick", count, 8'd8);
    inv = 1'b1;
    step(1);
    chk("t6_inv_tout", timer_out, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_count", count, 8'd0);
    chk("t6_arst_tout", timer_out, 8'd0);
    chk("t6_arst_ovf", overflow, 8'd0);
    step(1);
    chk("t6_rst_hold", count, 8'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
